// File: rtl/trig_capture_fifo_pkg.sv
// Shared encodings for the trigger capture buffer: FSM states and trigger modes.
package trig_capture_fifo_pkg;

   typedef enum logic [2:0] {
      CAP_IDLE      = 3'd0,
      CAP_PREFILL   = 3'd1,
      CAP_WAIT_TRIG = 3'd2,
      CAP_POST      = 3'd3,
      CAP_DONE      = 3'd4
   } cap_state_e;

   typedef enum logic [1:0] {
      TRIG_IMMEDIATE = 2'd0,
      TRIG_EXT_EDGE  = 2'd1,
      TRIG_SOFTWARE  = 2'd2,
      TRIG_RESERVED  = 2'd3
   } trig_mode_e;

endpackage

// File: rtl/trig_capture_fifo_capture_bram.sv
// Simple dual-port single-clock RAM with registered read port; contents are never reset.
module capture_bram #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/trig_capture_fifo.sv
// Pre/post-trigger capture buffer: circular prefill, trigger qualification, post fill, linear readout.
module trig_capture_fifo
   import trig_capture_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 256,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned PRE_TRIG_DEPTH = 512
) (
   input  logic                  i_cap_clk,
   input  logic                  i_cap_reset,
   input  logic [DATA_WIDTH-1:0] i_cap_wr_data,
   input  logic                  i_cap_wr_en,
   input  logic                  i_cap_arm,
   input  logic [1:0]            i_cap_trig_mode,
   input  logic                  i_cap_ext_trig,
   input  logic                  i_cap_sw_trig,
   input  logic                  i_cap_rd_en,
   output logic [DATA_WIDTH-1:0] o_cap_rd_data,
   output logic                  o_cap_rd_valid,
   output logic [2:0]            o_cap_state,
   output logic                  o_cap_done,
   output logic                  o_cap_empty,
   output logic [ADDR_WIDTH-1:0] o_cap_trig_addr
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   PRE_CNT   = (ADDR_WIDTH+1)'(PRE_TRIG_DEPTH);
   localparam logic [ADDR_WIDTH:0]   POST_CNT  = DEPTH_CNT - PRE_CNT;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PRE_ADDR  = ADDR_WIDTH'(PRE_TRIG_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   cap_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q, trig_addr_q;
   logic [ADDR_WIDTH:0]   cnt_q, rd_cnt_q, cnt_inc;
   logic                  rd_valid_q;
   logic                  ext_meta_q, ext_sync_q, ext_prev_q;
   logic                  trig_q, wr_fire, rd_fire, trig_fire, empty;

   assign cnt_inc = cnt_q + CNT_ONE;
   assign empty   = (state_q != CAP_DONE) || (rd_cnt_q == DEPTH_CNT);

   always_comb begin
      trig_q = 1'b0;
      case (trig_mode_e'(i_cap_trig_mode))
         TRIG_IMMEDIATE: trig_q = 1'b1;
         TRIG_EXT_EDGE:  trig_q = ext_sync_q & ~ext_prev_q;
         default:        trig_q = i_cap_sw_trig;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wr_fire   = 1'b0;
      rd_fire   = 1'b0;
      trig_fire = 1'b0;
      if (i_cap_arm) begin
         state_d = CAP_PREFILL;
      end else begin
         case (state_q)
            CAP_IDLE: ;
            CAP_PREFILL: begin
               wr_fire = i_cap_wr_en;
               if (PRE_CNT == '0 || (i_cap_wr_en && cnt_inc == PRE_CNT)) begin
                  state_d = CAP_WAIT_TRIG;
               end
            end
            CAP_WAIT_TRIG: begin
               // The write in the trigger cycle lands at trig_addr and is the first post word.
               wr_fire = i_cap_wr_en;
               if (trig_q) begin
                  trig_fire = 1'b1;
                  state_d   = (i_cap_wr_en && POST_CNT == CNT_ONE) ? CAP_DONE : CAP_POST;
               end
            end
            CAP_POST: begin
               wr_fire = i_cap_wr_en;
               if (i_cap_wr_en && cnt_inc == POST_CNT) begin
                  state_d = CAP_DONE;
               end
            end
            CAP_DONE: rd_fire = i_cap_rd_en && !empty;
            default: state_d = CAP_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_cap_clk or posedge i_cap_reset) begin
      if (i_cap_reset) begin
         state_q <= CAP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_cap_clk or posedge i_cap_reset) begin
      if (i_cap_reset) begin
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         trig_addr_q <= '0;
         cnt_q       <= '0;
         rd_cnt_q    <= '0;
         rd_valid_q  <= 1'b0;
         ext_meta_q  <= 1'b0;
         ext_sync_q  <= 1'b0;
         ext_prev_q  <= 1'b0;
      end else begin
         ext_meta_q <= i_cap_ext_trig;
         ext_sync_q <= ext_meta_q;
         ext_prev_q <= ext_sync_q;
         rd_valid_q <= rd_fire;
         if (i_cap_arm) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
         end else begin
            if (wr_fire) begin
               wr_addr_q <= wr_addr_q + ADDR_ONE;
            end
            if (trig_fire) begin
               trig_addr_q <= wr_addr_q;
               rd_addr_q   <= wr_addr_q - PRE_ADDR;
               cnt_q       <= i_cap_wr_en ? CNT_ONE : '0;
            end else if (wr_fire) begin
               cnt_q <= cnt_inc;
            end
            if (rd_fire) begin
               rd_addr_q <= rd_addr_q + ADDR_ONE;
               rd_cnt_q  <= rd_cnt_q + CNT_ONE;
            end
         end
      end
   end

   capture_bram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_capture_bram (
      .clk     (i_cap_clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_addr_q),
      .wr_data (i_cap_wr_data),
      .rd_en   (rd_fire),
      .rd_addr (rd_addr_q),
      .rd_data (o_cap_rd_data)
   );

   assign o_cap_rd_valid  = rd_valid_q;
   assign o_cap_state     = state_q;
   assign o_cap_done      = (state_q == CAP_DONE);
   assign o_cap_empty     = empty;
   assign o_cap_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_trig_capture_fifo.sv
// Self-checking bench: scenario table, directed corner sequences and random traffic vs a reference model.
module tb_trig_capture_fifo;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int PRE   = 4;
   localparam int DEPTH = 16;
   localparam int POSTN = DEPTH - PRE;

   logic          clk = 1'b0;
   logic          i_cap_reset;
   logic [DW-1:0] i_cap_wr_data;
   logic          i_cap_wr_en, i_cap_arm, i_cap_ext_trig, i_cap_sw_trig, i_cap_rd_en;
   logic [1:0]    i_cap_trig_mode;
   logic [DW-1:0] o_cap_rd_data;
   logic          o_cap_rd_valid, o_cap_done, o_cap_empty;
   logic [2:0]    o_cap_state;
   logic [AW-1:0] o_cap_trig_addr;

   always #5 clk = ~clk;

   trig_capture_fifo #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .PRE_TRIG_DEPTH (PRE)
   ) dut (
      .i_cap_clk       (clk),
      .i_cap_reset     (i_cap_reset),
      .i_cap_wr_data   (i_cap_wr_data),
      .i_cap_wr_en     (i_cap_wr_en),
      .i_cap_arm       (i_cap_arm),
      .i_cap_trig_mode (i_cap_trig_mode),
      .i_cap_ext_trig  (i_cap_ext_trig),
      .i_cap_sw_trig   (i_cap_sw_trig),
      .i_cap_rd_en     (i_cap_rd_en),
      .o_cap_rd_data   (o_cap_rd_data),
      .o_cap_rd_valid  (o_cap_rd_valid),
      .o_cap_state     (o_cap_state),
      .o_cap_done      (o_cap_done),
      .o_cap_empty     (o_cap_empty),
      .o_cap_trig_addr (o_cap_trig_addr)
   );

   typedef struct {
      logic [1:0]    mode;
      int            trig;
      int            sw_pre;
      logic [AW-1:0] exp_taddr;
      logic [DW-1:0] exp_first;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase numbers follow the documented state numbering.
   int            m_phase, m_wcount, m_post, m_reads;
   logic [AW-1:0] m_taddr;
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          h1, h2, h3;
   logic [1:0]    cur_mode;
   int            w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_wcount = 0; m_post = 0; m_reads = 0;
      m_taddr = '0; m_valid = 1'b0; m_data = '0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
   endtask

   task automatic model_write(input logic [DW-1:0] d);
      m_mem[m_wcount % DEPTH] = d;
      m_wcount++;
   endtask

   task automatic compare_all();
      check("state", 32'(o_cap_state), 32'(m_phase));
      check("done", 32'(o_cap_done), 32'(m_phase == 4));
      check("empty", 32'(o_cap_empty), 32'(!(m_phase == 4 && m_reads < DEPTH)));
      check("trig_addr", 32'(o_cap_trig_addr), 32'(m_taddr));
      check("rd_valid", 32'(o_cap_rd_valid), 32'(m_valid));
      if (m_valid) check("rd_data", 32'(o_cap_rd_data), 32'(m_data));
   endtask

   task automatic tick(input logic arm, input logic wr, input logic [DW-1:0] d,
                       input logic sw, input logic ext, input logic rd);
      logic q;
      i_cap_arm = arm; i_cap_wr_en = wr; i_cap_wr_data = d;
      i_cap_sw_trig = sw; i_cap_ext_trig = ext; i_cap_rd_en = rd;
      i_cap_trig_mode = cur_mode;
      q = (cur_mode == 2'd0) ? 1'b1 : (cur_mode == 2'd1) ? (h2 & ~h3) : sw;
      m_valid = 1'b0;
      if (arm) begin
         m_phase = 1; m_wcount = 0; m_post = 0; m_reads = 0;
      end else begin
         case (m_phase)
            1: if (wr) begin
                  model_write(d);
                  if (m_wcount == PRE) m_phase = 2;
               end
            2: begin
                  if (q) begin
                     m_taddr = AW'(m_wcount % DEPTH);
                     m_post  = wr ? 1 : 0;
                     m_phase = 3;
                  end
                  if (wr) model_write(d);
               end
            3: if (wr) begin
                  model_write(d);
                  m_post++;
                  if (m_post == POSTN) m_phase = 4;
               end
            4: if (rd && m_reads < DEPTH) begin
                  m_valid = 1'b1;
                  m_data  = m_mem[(int'(m_taddr) + DEPTH - PRE + m_reads) % DEPTH];
                  m_reads++;
               end
            default: ;
         endcase
      end
      h3 = h2; h2 = h1; h1 = ext;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run_capture(input logic [1:0] mode, input int trig, input int sw_pre);
      logic sw, ext;
      cur_mode = mode;
      tick(1'b1, 1'b1, 16'hdead, 1'b0, 1'b0, 1'b0);
      w = 0;
      for (int g = 0; g < 100 && !o_cap_done; g++) begin
         sw  = (mode >= 2'd2) && (w == trig || w == sw_pre);
         ext = (mode == 2'd1) && (w >= trig);
         tick(1'b0, 1'b1, w[DW-1:0], sw, ext, 1'b0);
         if (w == sw_pre) check("prefill_ignores_trig", 32'(o_cap_state), 32'd1);
         if (w == PRE - 1) check("enter_wait_trig", 32'(o_cap_state), 32'd2);
         if (mode == 2'd1 && w == trig + 1) check("ext_not_yet", 32'(o_cap_state), 32'd2);
         if (mode == 2'd1 && w == trig + 2) check("ext_post_3cyc", 32'(o_cap_state), 32'd3);
         w++;
      end
      check("capture_done", 32'(o_cap_done), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      run_capture(v.mode, v.trig, v.sw_pre);
      check("vec_trig_addr", 32'(o_cap_trig_addr), 32'(v.exp_taddr));
      for (int i = 0; i <= DEPTH; i++) begin
         tick(1'b0, 1'b1, w[DW-1:0], 1'b0, 1'b0, 1'b1);
         w++;
         if (i == 0) begin
            check("first_valid", 32'(o_cap_rd_valid), 32'd1);
            check("first_read", 32'(o_cap_rd_data), 32'(v.exp_first));
         end
         if (i == DEPTH) begin
            check("overread_valid", 32'(o_cap_rd_valid), 32'd0);
            check("overread_empty", 32'(o_cap_empty), 32'd1);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [5];
      logic ext_r;
      vecs[0] = '{mode: 2'd2, trig: 10, sw_pre: -1, exp_taddr: 4'd10, exp_first: 16'd6};
      vecs[1] = '{mode: 2'd2, trig: 10, sw_pre: 2,  exp_taddr: 4'd10, exp_first: 16'd6};
      vecs[2] = '{mode: 2'd0, trig: -1, sw_pre: -1, exp_taddr: 4'd4,  exp_first: 16'd0};
      vecs[3] = '{mode: 2'd1, trig: 7,  sw_pre: -1, exp_taddr: 4'd9,  exp_first: 16'd5};
      vecs[4] = '{mode: 2'd3, trig: 20, sw_pre: -1, exp_taddr: 4'd4,  exp_first: 16'd16};

      i_cap_reset = 1'b1; i_cap_arm = 1'b0; i_cap_wr_en = 1'b0; i_cap_wr_data = '0;
      i_cap_sw_trig = 1'b0; i_cap_ext_trig = 1'b0; i_cap_rd_en = 1'b0; i_cap_trig_mode = '0;
      cur_mode = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(o_cap_state), 32'd0);
      check("rst_done", 32'(o_cap_done), 32'd0);
      check("rst_empty", 32'(o_cap_empty), 32'd1);
      check("rst_valid", 32'(o_cap_rd_valid), 32'd0);
      check("rst_trig_addr", 32'(o_cap_trig_addr), 32'd0);
      i_cap_reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Reset while in POST abandons the capture; a fresh arm then completes normally.
      cur_mode = 2'd2;
      tick(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) tick(1'b0, 1'b1, k[DW-1:0], k == 6, 1'b0, 1'b0);
      check("in_post", 32'(o_cap_state), 32'd3);
      #2 i_cap_reset = 1'b1;
      #1;
      model_reset();
      check("midrst_state", 32'(o_cap_state), 32'd0);
      check("midrst_done", 32'(o_cap_done), 32'd0);
      check("midrst_empty", 32'(o_cap_empty), 32'd1);
      compare_all();
      @(posedge clk);
      #1 i_cap_reset = 1'b0;
      run_vec(vecs[0]);

      // Arm during readout restarts and later read requests are ignored.
      run_capture(2'd0, -1, -1);
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1'b1);
      check("rearm_state", 32'(o_cap_state), 32'd1);
      check("rearm_done", 32'(o_cap_done), 32'd0);
      check("rearm_valid", 32'(o_cap_rd_valid), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, k[DW-1:0], 1'b0, 1'b0, 1'b1);
         check("rearm_rd_ignored", 32'(o_cap_rd_valid), 32'd0);
      end

      ext_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic arm;
         arm = ($urandom % 150) == 0;
         if (arm) cur_mode = 2'($urandom % 4);
         if ($urandom % 8 == 0) ext_r = ~ext_r;
         tick(arm, ($urandom % 4) != 0, 16'($urandom), ($urandom % 16) == 0, ext_r,
              ($urandom % 2) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
